mac_seq_ctrl: RTL and testbench

- Sequencer for the 4-lane MAC dot-product datapath: psum = x0·w0 + x1·w1 + x2·w2 + x3·w3 + psum_in.
- Runs a dot product of len groups of 4 operand pairs, streamed over a valid/ready input channel.
- Owns the partial-sum accumulator and feeds it back as the datapath psum_in; returns the final sum on a valid/ready output channel.
- Sits between the operand fetch logic and the MAC datapath; the datapath is instantiated beside it at top level.

---
 rtl/mac_pkg.sv | 18 +
 rtl/mac_seq_ctrl.sv | 75 +++++++
 tb/tb_mac_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and state encodings for the MAC sequencer
package mac_pkg;

  localparam int LANES   = 4;
  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int CNT_BW  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The unused code 2'd3 behaves as IDLE, so a corrupted state register recovers on its own.
  function automatic logic [1:0] state_decode(input logic [1:0] s);
    return (s == 2'd3) ? ST_IDLE : s;
  endfunction

endpackage

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - job sequencer and accumulator owner for the 4-lane MAC datapath
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int bw      = BW,
  parameter int psum_bw = PSUM_BW,
  parameter int cnt_bw  = CNT_BW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [cnt_bw-1:0]     len,
  input  logic                  abort,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*bw-1:0]   in_x,
  input  logic [LANES*bw-1:0]   in_w,
  output logic [LANES*bw-1:0]   dp_x,
  output logic [LANES*bw-1:0]   dp_w,
  output logic [psum_bw-1:0]    dp_psum,
  input  logic [psum_bw-1:0]    dp_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [psum_bw-1:0]    out_data
);

  logic [1:0]         state;
  logic [1:0]         st;
  logic [psum_bw-1:0] acc;
  logic [cnt_bw-1:0]  cnt;
  logic               xfer;
  logic               accept;

  assign st   = state_decode(state);
  assign xfer = (st == ST_RUN) && in_valid;

  // A new job is taken from IDLE, or from DONE in the same cycle the result is consumed.
  assign accept = start && ((st == ST_IDLE) || ((st == ST_DONE) && out_ready));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= (len != '0) ? ST_RUN : ST_DONE;
      acc   <= '0;
      cnt   <= len;
    end else if (xfer) begin
      acc <= dp_out;
      cnt <= cnt - cnt_bw'(1);
      state <= (cnt == cnt_bw'(1)) ? ST_DONE : ST_RUN;
    end else if ((st == ST_DONE) && out_ready) begin
      state <= ST_IDLE;
    end else begin
      state <= st;
    end
  end

  assign busy      = (st != ST_IDLE);
  assign in_ready  = (st == ST_RUN);
  assign out_valid = (st == ST_DONE);
  assign out_data  = acc;
  assign dp_psum   = acc;

  // Operands are zeroed outside transfers so the datapath stays quiet.
  assign dp_x = xfer ? in_x : '0;
  assign dp_w = xfer ? in_w : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - scoreboard bench for mac_seq_ctrl with a behavioural datapath
module tb_mac_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        abort;
  logic        in_valid;
  logic [15:0] in_x;
  logic [15:0] in_w;
  logic        out_ready;

  logic        busy, in_ready, out_valid;
  logic [15:0] dp_x, dp_w, dp_psum, dp_out, out_data;

  logic        busy8, in_ready8, out_valid8;
  logic [15:0] dp_x8, dp_w8;
  logic [7:0]  dp_psum8, dp_out8, out_data8;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] dot4(input logic [15:0] x, input logic [15:0] w);
    logic [31:0] s;
    s = 0;
    for (int i = 0; i < 4; i++) s += 32'(x[i*4 +: 4]) * 32'(w[i*4 +: 4]);
    return s;
  endfunction

  assign dp_out  = 16'(dot4(dp_x, dp_w) + 32'(dp_psum));
  assign dp_out8 = 8'(dot4(dp_x8, dp_w8) + 32'(dp_psum8));

  mac_seq_ctrl #(.bw(4), .psum_bw(16), .cnt_bw(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .dp_x(dp_x), .dp_w(dp_w), .dp_psum(dp_psum), .dp_out(dp_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  mac_seq_ctrl #(.bw(4), .psum_bw(8), .cnt_bw(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort), .busy(busy8),
    .in_valid(in_valid), .in_ready(in_ready8), .in_x(in_x), .in_w(in_w),
    .dp_x(dp_x8), .dp_w(dp_w8), .dp_psum(dp_psum8), .dp_out(dp_out8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input string tag, input logic [15:0] x, input logic [15:0] w);
    in_valid = 1'b1;
    in_x = x;
    in_w = w;
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 1);
    chk({tag, "_dpx"}, 32'(dp_x), 32'(x));
    chk({tag, "_ov"}, 32'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_x = '0;
    in_w = '0;
  endtask

  task automatic expect_result(input string tag);
    logic [31:0] e;
    int n;
    n = 0;
    while (!out_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_valid8"}, 32'(out_valid8), 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_data"}, 32'(out_data), 32'(e[15:0]));
    chk({tag, "_data8"}, 32'(out_data8), 32'(e[7:0]));
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_ov_low"}, 32'(out_valid), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state, with operands presented to confirm gating outside RUN
    in_valid = 1'b1; in_x = 16'hffff; in_w = 16'hffff;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(in_ready), 0);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_psum", 32'(dp_psum), 0);
    chk("rst_dpx", 32'(dp_x), 0);
    chk("rst_dpw", 32'(dp_w), 0);
    reset = 1'b0;
    in_valid = 1'b0; in_x = '0; in_w = '0;
    @(negedge clk);

    // basic job: 3 groups of 10 each, result on the 4th cycle after start
    exp_q.push_back(30);
    start_job(8'd3);
    send("b1", 16'h4321, 16'h1111);
    send("b2", 16'h4321, 16'h1111);
    send("b3", 16'h4321, 16'h1111);
    #1;
    chk("basic_latency", 32'(out_valid), 1);
    expect_result("basic");
    take("basic");

    // stall between groups: acc holds at 8, in_ready stays high
    exp_q.push_back(16);
    start_job(8'd2);
    send("s1", 16'h1111, 16'h2222);
    for (int i = 0; i < 5; i++) begin
      in_x = 16'hffff; in_w = 16'hffff;
      #1;
      chk("stall_rdy", 32'(in_ready), 1);
      chk("stall_psum", 32'(dp_psum), 8);
      chk("stall_dpx", 32'(dp_x), 0);
      chk("stall_ov", 32'(out_valid), 0);
      @(negedge clk);
    end
    send("s2", 16'h1111, 16'h2222);
    expect_result("stall");
    take("stall");

    // zero-length job under backpressure
    exp_q.push_back(0);
    start_job(8'd0);
    #1;
    chk("zero_next", 32'(out_valid), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_ov", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 0);
    end
    expect_result("zero");
    take("zero");

    // back-to-back: new start accepted with the result handshake
    exp_q.push_back(6);
    start_job(8'd1);
    send("bb1", 16'h0002, 16'h0003);
    expect_result("b2b_first");
    out_ready = 1'b1; start = 1'b1; len = 8'd1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    #1;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_rdy", 32'(in_ready), 1);
    chk("b2b_ov", 32'(out_valid), 0);
    chk("b2b_acc0", 32'(dp_psum), 0);
    exp_q.push_back(7);
    send("bb2", 16'h0001, 16'h0007);
    expect_result("b2b_second");
    take("b2b");

    // wrap-around: 1800 in 16 bits, 8 in 8 bits
    exp_q.push_back(1800);
    start_job(8'd2);
    send("w1", 16'hffff, 16'hffff);
    send("w2", 16'hffff, 16'hffff);
    expect_result("wrap");
    take("wrap");

    // abort after 1 of 3 groups, with a transfer offered in the abort cycle
    start_job(8'd3);
    send("a1", 16'h1111, 16'h1111);
    #1;
    chk("abort_pre_psum", 32'(dp_psum), 4);
    abort = 1'b1; in_valid = 1'b1; in_x = 16'h1111; in_w = 16'h1111;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_psum", 32'(dp_psum), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_ov", 32'(out_valid), 0);
    end

    // asynchronous reset between edges mid-RUN
    start_job(8'd2);
    send("r1", 16'h1111, 16'h2222);
    in_valid = 1'b1; in_x = 16'h1111; in_w = 16'h2222;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdy", 32'(in_ready), 0);
    chk("arst_ov", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_psum", 32'(dp_psum), 0);
    chk("arst_dpx", 32'(dp_x), 0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_x = '0; in_w = '0;
    repeat (2) @(negedge clk);
    chk("arst_idle", 32'(busy), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
